retospect_cfg_loader: RTL and testbench
=======================================

# retospect_cfg_loader

Byte-wide configuration loader sitting directly upstream of the neurochip CNB shift chain. Accepts configuration bytes from the host pins over a valid/ready handshake and serialises them LSB-first into the chain, driving the chain's `config_en` and serial-in `bs_in`. Counts shifted bits and stops after exactly `CHAIN_BITS`, so the host never has to time `config_en` itself. Optionally checks a trailing CRC-8 byte.

## Interface

- `CHAIN_BITS`, 684, total chain length in bits (36 cells × 19 bits: w1..w4 3b each, uT 4b, clockDecaySelect 3b)
- `CNT_W`, `$clog2(CHAIN_BITS+1)`, bit-counter width (derived, not overridden)

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE
- `abort`  in  1  synchronous; returns to IDLE from any state
- `byte_in`  in  8  configuration byte
- `byte_valid`  in  1  `byte_in` valid
- `byte_ready`  out  1  loader can accept a byte this cycle
- `config_en`  out  1  to chain; high exactly on shift cycles
- `bs_out`  out  1  to chain `bs_in`; bit being shifted
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse, load completed
- `error`  out  1  sticky CRC mismatch flag; cleared on `start` (0 without CRC)

## Operation

- States: IDLE, WAIT_BYTE, SHIFT, WAIT_CRC (CRC build only), DONE.
- IDLE: `start` → clear bit counter, clear CRC reg to 0x00, clear `error`, → WAIT_BYTE.
- WAIT_BYTE: `byte_ready`=1. On `byte_valid & byte_ready`: latch `byte_in` into 8b shift reg, clear sub-bit index, → SHIFT.
- SHIFT: each cycle `config_en`=1, `bs_out`=sr[0]; sr shifts right; bit counter +1; sub-bit index +1.
  - Counter reaches `CHAIN_BITS` on this cycle → WAIT_CRC (CRC build) or DONE; remaining bits of that byte discarded.
  - Else sub-bit index reaches 8 → WAIT_BYTE.
- Byte count required: ceil(CHAIN_BITS/8) = 86 for default; final byte's upper 4 bits ignored.
- WAIT_CRC: `byte_ready`=1; accepted byte compared to CRC reg; mismatch sets `error`; → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `start` outside IDLE ignored. `byte_valid` while `byte_ready`=0 ignored (byte not consumed).
- `abort`: → IDLE next edge, `config_en` low from that edge, no `done`, `error` unchanged. Chain contents left partially shifted.
- `abort` and `start` same cycle in IDLE: `abort` wins.

## Timing

- Reset values: `byte_ready`=0, `config_en`=0, `bs_out`=0, `busy`=0, `done`=0, `error`=0; state IDLE, counters 0.
- All outputs registered or decoded from state register only; no combinational path from inputs to outputs.
- `start` at edge N → `busy`=1, `byte_ready`=1 from N+1.
- Byte accepted at edge N → `config_en`=1 with bit 0 on `bs_out` for cycles N+1..N+8; `byte_ready` high again at N+9. Throughput 9 cycles/byte.
- Chain samples `bs_out` on the same edge that ends a `config_en`=1 cycle; exactly `CHAIN_BITS` such cycles per completed load.
- Last shift cycle at edge M → `done` high at M+1 (no CRC); with CRC, `done` one cycle after CRC byte acceptance.
- Reset mid-SHIFT: `config_en` drops asynchronously, no further shifts.

## Configuration

- `RETOSPECT_CFG_CRC_EN` defined: CRC-8, poly 0x07, init 0x00, updated per shifted bit: fb = crc[7]^bit; crc = {crc[6:0],0} ^ (fb ? 0x07 : 0x00). Discarded tail bits excluded. WAIT_CRC state present; one extra byte required.
- Undefined: no CRC logic, no WAIT_CRC; `error` tied 0; SHIFT → DONE directly.

## Test plan

- Full load, bytes 0x00..0x55 back-to-back (86 bytes) → exactly 684 `config_en` cycles, `bs_out` sequence = bytes LSB-first, last byte bits 4..7 never driven, one `done` pulse.
- `byte_valid` with random 0–5 cycle gaps → `config_en` only during SHIFT, identical bit stream, no dropped/duplicated byte.
- `CHAIN_BITS`=19, bytes 0xA5,0x3C,0x07 → 19 shifts, `done` one cycle after 19th shift.
- Assert `reset` after 100 shifts → all outputs at reset values immediately, IDLE; next `start` loads cleanly from bit 0.
- `start` pulses while busy, `abort` at shift 40 → start ignored; after abort `busy`=0, no `done`, 40 shifts total.
- CRC build: correct trailing CRC → `error`=0, `done`=1; CRC byte XOR 0x01 → `error`=1 sticky until next `start`.

Source files
------------

// File: rtl/retospect_cfg_loader.sv
// Byte-wide valid/ready loader that serialises configuration bytes LSB-first into the CNB shift chain.
// Define RETOSPECT_CFG_CRC_EN to require and check a trailing CRC-8 (poly 0x07, init 0x00) byte.
module retospect_cfg_loader #(
   parameter int unsigned CHAIN_BITS = 684
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       config_en,
   output logic       bs_out,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int unsigned      CNT_W    = $clog2(CHAIN_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_BITS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_BYTE,
      S_SHIFT,
`ifdef RETOSPECT_CFG_CRC_EN
      S_WAIT_CRC,
`endif
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [2:0]       sub_q, sub_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         sub_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         sub_q   <= sub_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      sub_d   = sub_q;
      cnt_inc = cnt_q + CNT_W'(1);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d   = '0;
               state_d = S_WAIT_BYTE;
            end
         end
         S_WAIT_BYTE: begin
            if (byte_valid) begin
               sr_d    = byte_in;
               sub_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sr_d  = {1'b0, sr_q[7:1]};
            cnt_d = cnt_inc;
            sub_d = sub_q + 3'd1;
            // Chain length wins over byte boundary: leftover bits of the final byte are dropped.
            if (cnt_inc == LAST_CNT) begin
`ifdef RETOSPECT_CFG_CRC_EN
               state_d = S_WAIT_CRC;
`else
               state_d = S_DONE;
`endif
            end else if (sub_q == 3'd7) begin
               state_d = S_WAIT_BYTE;
            end
         end
`ifdef RETOSPECT_CFG_CRC_EN
         S_WAIT_CRC: begin
            if (byte_valid) begin
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (abort) begin
         state_d = S_IDLE;
      end
   end

`ifdef RETOSPECT_CFG_CRC_EN
   logic [7:0] crc_q, crc_d;
   logic       error_q, error_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crc_q   <= '0;
         error_q <= 1'b0;
      end else begin
         crc_q   <= crc_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      crc_d   = crc_q;
      error_d = error_q;
      if (state_q == S_IDLE && start && !abort) begin
         crc_d   = '0;
         error_d = 1'b0;
      end else if (state_q == S_SHIFT) begin
         crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ sr_q[0]) ? 8'h07 : 8'h00);
      end else if (state_q == S_WAIT_CRC && byte_valid && !abort && byte_in != crc_q) begin
         error_d = 1'b1;
      end
   end

   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   always_comb begin
      byte_ready = (state_q == S_WAIT_BYTE);
`ifdef RETOSPECT_CFG_CRC_EN
      byte_ready = byte_ready | (state_q == S_WAIT_CRC);
`endif
      config_en = (state_q == S_SHIFT);
      bs_out    = (state_q == S_SHIFT) & sr_q[0];
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
   end

endmodule

// File: tb/tb_retospect_cfg_loader.sv
// Self-checking bench for retospect_cfg_loader: a full-length and a 19-bit instance, bit-stream scoreboards.
module tb_retospect_cfg_loader;

   localparam int unsigned BITS_A  = 684;
   localparam int unsigned BITS_B  = 19;
   localparam int unsigned BYTES_A = (BITS_A + 7) / 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1;
   logic       start_a = 1'b0, abort_a = 1'b0, valid_a = 1'b0;
   logic [7:0] byte_a = '0;
   logic       ready_a, cen_a, bs_a, busy_a, done_a, err_a;
   logic       start_b = 1'b0, abort_b = 1'b0, valid_b = 1'b0;
   logic [7:0] byte_b = '0;
   logic       ready_b, cen_b, bs_b, busy_b, done_b, err_b;

   retospect_cfg_loader #(.CHAIN_BITS(BITS_A)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
      .byte_in(byte_a), .byte_valid(valid_a), .byte_ready(ready_a),
      .config_en(cen_a), .bs_out(bs_a), .busy(busy_a), .done(done_a), .error(err_a)
   );

   retospect_cfg_loader #(.CHAIN_BITS(BITS_B)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
      .byte_in(byte_b), .byte_valid(valid_b), .byte_ready(ready_b),
      .config_en(cen_b), .bs_out(bs_b), .busy(busy_b), .done(done_b), .error(err_b)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Scoreboards: expected chain bits pushed at byte acceptance, popped on every config_en cycle.
   bit         exp_a[$];
   bit         exp_b[$];
   int         shifts_a, dones_a, last_shift_a, done_cyc_a, pushed_a;
   int         shifts_b, dones_b, last_shift_b, done_cyc_b, pushed_b;
   logic [7:0] crc_a, crc_b;
   bit         eb_a, eb_b;

   always @(negedge clk) begin
      if (cen_a === 1'b1) begin
         shifts_a++;
         last_shift_a = cyc;
         if (exp_a.size() == 0) chk("a_unexpected_shift", 32'(shifts_a), 32'(pushed_a));
         else begin
            eb_a = exp_a.pop_front();
            chk("a_bs_out", {31'b0, bs_a}, {31'b0, eb_a});
         end
      end
      if (done_a === 1'b1) begin
         dones_a++;
         done_cyc_a = cyc;
      end
   end

   always @(negedge clk) begin
      if (cen_b === 1'b1) begin
         shifts_b++;
         last_shift_b = cyc;
         if (exp_b.size() == 0) chk("b_unexpected_shift", 32'(shifts_b), 32'(pushed_b));
         else begin
            eb_b = exp_b.pop_front();
            chk("b_bs_out", {31'b0, bs_b}, {31'b0, eb_b});
         end
      end
      if (done_b === 1'b1) begin
         dones_b++;
         done_cyc_b = cyc;
      end
   end

   function automatic logic [7:0] crc_step(input logic [7:0] c, input bit b);
      return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load_a();
      exp_a.delete();
      pushed_a = 0; crc_a = 8'h00; shifts_a = 0; dones_a = 0;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("a_busy_after_start", {31'b0, busy_a}, 1);
      chk("a_ready_after_start", {31'b0, ready_a}, 1);
   endtask

   task automatic start_load_b();
      exp_b.delete();
      pushed_b = 0; crc_b = 8'h00; shifts_b = 0; dones_b = 0;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk("b_busy_after_start", {31'b0, busy_b}, 1);
   endtask

   task automatic send_a(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) tick();
      valid_a = 1'b1;
      byte_a  = b;
      t = 0;
      while (ready_a !== 1'b1 && t < 50) begin tick(); t++; end
      if (t >= 50) chk("a_ready_timeout", {31'b0, ready_a}, 1);
      for (int i = 0; i < 8; i++) begin
         if (pushed_a < int'(BITS_A)) begin
            exp_a.push_back(b[i]);
            crc_a = crc_step(crc_a, b[i]);
            pushed_a++;
         end
      end
      tick();
      valid_a = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] b);
      int t;
      valid_b = 1'b1;
      byte_b  = b;
      t = 0;
      while (ready_b !== 1'b1 && t < 50) begin tick(); t++; end
      if (t >= 50) chk("b_ready_timeout", {31'b0, ready_b}, 1);
      for (int i = 0; i < 8; i++) begin
         if (pushed_b < int'(BITS_B)) begin
            exp_b.push_back(b[i]);
            crc_b = crc_step(crc_b, b[i]);
            pushed_b++;
         end
      end
      tick();
      valid_b = 1'b0;
   endtask

   task automatic finish_a(input string tag);
      int t;
`ifdef RETOSPECT_CFG_CRC_EN
      send_a(crc_a, 0);
`endif
      t = 0;
      while (dones_a == 0 && t < 40) begin tick(); t++; end
      tick();
      chk({tag, "_shifts"}, 32'(shifts_a), 32'(BITS_A));
      chk({tag, "_done_pulses"}, 32'(dones_a), 1);
      chk({tag, "_queue_left"}, 32'(exp_a.size()), 0);
`ifndef RETOSPECT_CFG_CRC_EN
      chk({tag, "_done_latency"}, 32'(done_cyc_a), 32'(last_shift_a + 1));
`endif
      chk({tag, "_busy_end"}, {31'b0, busy_a}, 0);
      chk({tag, "_error"}, {31'b0, err_a}, 0);
   endtask

   task automatic load_b(input logic [7:0] crc_xor, input string tag);
      int t;
      start_load_b();
      send_b(8'hA5);
      send_b(8'h3C);
      send_b(8'h07);
`ifdef RETOSPECT_CFG_CRC_EN
      send_b(crc_b ^ crc_xor);
`endif
      t = 0;
      while (dones_b == 0 && t < 40) begin tick(); t++; end
      tick();
      chk({tag, "_shifts"}, 32'(shifts_b), 32'(BITS_B));
      chk({tag, "_done_pulses"}, 32'(dones_b), 1);
      chk({tag, "_queue_left"}, 32'(exp_b.size()), 0);
`ifndef RETOSPECT_CFG_CRC_EN
      chk({tag, "_done_latency"}, 32'(done_cyc_b), 32'(last_shift_b + 1));
`endif
      chk({tag, "_error"}, {31'b0, err_b}, {31'b0, (crc_xor != 8'h00)});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_outputs", {26'b0, ready_a, cen_a, bs_a, busy_a, done_a, err_a}, 0);
      chk("rst_b_outputs", {26'b0, ready_b, cen_b, bs_b, busy_b, done_b, err_b}, 0);
      reset = 1'b0;
      tick();

      // Full back-to-back load with throughput check on the first byte.
      start_load_a();
      send_a(8'h00, 0);
      chk("a_cen_after_accept", {31'b0, cen_a}, 1);
      repeat (7) tick();
      chk("a_cen_8th_cycle", {30'b0, cen_a, ready_a}, 32'h2);
      tick();
      chk("a_ready_after_byte", {30'b0, cen_a, ready_a}, 32'h1);
      for (int i = 1; i < int'(BYTES_A); i++) send_a(8'(i), 0);
      finish_a("full");

      // Reset after exactly 100 shifts.
      start_load_a();
      for (int i = 0; i < 13; i++) send_a(8'(i + 8'h80), 0);
      t = 0;
      while (shifts_a < 100 && t < 40) begin @(negedge clk); #2; t++; end
      chk("rst_mid_shift_count", 32'(shifts_a), 100);
      reset = 1'b1;
      #1;
      chk("rst_mid_outputs", {26'b0, ready_a, cen_a, bs_a, busy_a, done_a, err_a}, 0);
      tick(); tick();
      chk("rst_mid_no_more_shifts", 32'(shifts_a), 100);
      reset = 1'b0;
      tick();

      // Clean reload from bit 0 with random host gaps.
      start_load_a();
      for (int i = 0; i < int'(BYTES_A); i++) send_a(8'(i), int'($urandom_range(0, 5)));
      finish_a("gaps");

      // Start pulses while busy are ignored, abort after 40 shifts.
      start_load_a();
      for (int i = 0; i < 5; i++) begin
         send_a(8'(8'hC3 ^ i), 0);
         start_a = 1'b1;
         tick();
         start_a = 1'b0;
      end
      t = 0;
      while (shifts_a < 40 && t < 40) begin tick(); t++; end
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      chk("abort_state", {29'b0, busy_a, ready_a, cen_a}, 0);
      repeat (5) tick();
      chk("abort_shifts", 32'(shifts_a), 40);
      chk("abort_no_done", 32'(dones_a), 0);
      chk("abort_queue_left", 32'(exp_a.size()), 0);

      // Abort during SHIFT drops config_en at the next edge.
      start_load_a();
      send_a(8'hFF, 0);
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      chk("abort_shift_cen", {30'b0, cen_a, busy_a}, 0);
      repeat (3) tick();
      chk("abort_shift_count", 32'(shifts_a), 1);
      exp_a.delete();

      // Abort beats start in IDLE.
      start_a = 1'b1;
      abort_a = 1'b1;
      tick();
      start_a = 1'b0;
      abort_a = 1'b0;
      chk("abort_beats_start", {31'b0, busy_a}, 0);

      // Short chain: final byte truncated after 3 bits.
      load_b(8'h00, "short");
`ifdef RETOSPECT_CFG_CRC_EN
      load_b(8'h01, "crc_bad");
      repeat (4) tick();
      chk("crc_err_sticky", {31'b0, err_b}, 1);
      start_load_b();
      chk("crc_err_cleared", {31'b0, err_b}, 0);
      abort_b = 1'b1;
      tick();
      abort_b = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
